// File: rtl/uart_frame_echo.sv
// UART frame buffer: gathers a frame from the serial input and echoes it forward or reversed.
// Define UART_FRAME_CKSUM_EN to append an XOR checksum byte after each echoed payload.
module uart_frame_echo #(
  parameter int unsigned NBYTES_MAX  = 16,
  parameter int unsigned CLK_FREQ    = 125_000_000,
  parameter int unsigned BAUD_RATE   = 115_200,
  parameter logic [7:0]  TERM_BYTE   = 8'h0D,
  parameter int unsigned TIMEOUT_CYC = 125_000
) (
  input  logic                              iClk,
  input  logic                              iRstN,
  input  logic                              iRx,
  output logic                              oTx,
  input  logic                              iMode,
  output logic                              oBusy,
  output logic [$clog2(NBYTES_MAX+1)-1:0]   oFrameLen,
  output logic [7:0]                        oFrameCnt,
  output logic [7:0]                        oDropCnt
);

  localparam int unsigned Cpb  = CLK_FREQ / BAUD_RATE;
  localparam int unsigned Half = Cpb / 2;
  localparam int unsigned BW   = $clog2(Cpb + 1);
  localparam int unsigned CW   = $clog2(NBYTES_MAX + 1);
  localparam int unsigned IW   = $clog2(NBYTES_MAX);
  localparam int unsigned RW   = CW + 1;
  localparam int unsigned TW   = $clog2(TIMEOUT_CYC + 1);
`ifdef UART_FRAME_CKSUM_EN
  localparam int unsigned CkExtra = 1;
`else
  localparam int unsigned CkExtra = 0;
`endif

  typedef enum logic [1:0] {StRx, StTxLoad, StTxWait, StDone} state_e;

  // ---------------- serial receiver ----------------
  logic [1:0]    rx_sync_q;
  logic          rx_in;
  logic          rx_active_q;
  logic [3:0]    rx_bit_q;
  logic [BW-1:0] rx_baud_q;
  logic [7:0]    rx_shift_q;
  logic          rx_done_q;

  assign rx_in = rx_sync_q[1];

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      rx_sync_q   <= 2'b11;
      rx_active_q <= 1'b0;
      rx_bit_q    <= '0;
      rx_baud_q   <= '0;
      rx_shift_q  <= '0;
      rx_done_q   <= 1'b0;
    end else begin
      rx_sync_q <= {rx_sync_q[0], iRx};
      rx_done_q <= 1'b0;
      if (!rx_active_q) begin
        if (!rx_in) begin
          rx_active_q <= 1'b1;
          rx_bit_q    <= '0;
          rx_baud_q   <= BW'(Half - 1);
        end
      end else if (rx_baud_q != '0) begin
        rx_baud_q <= rx_baud_q - 1'b1;
      end else begin
        rx_baud_q <= BW'(Cpb - 1);
        rx_bit_q  <= rx_bit_q + 4'd1;
        if (rx_bit_q == 4'd0) begin
          if (rx_in) rx_active_q <= 1'b0;  // glitch, not a real start bit
        end else if (rx_bit_q == 4'd9) begin
          rx_active_q <= 1'b0;
          rx_done_q   <= rx_in;            // framing error drops the byte
        end else begin
          rx_shift_q <= {rx_in, rx_shift_q[7:1]};
        end
      end
    end
  end

  // ---------------- serial transmitter ----------------
  logic          tx_start;
  logic [7:0]    tx_byte;
  logic          tx_busy_q;
  logic          tx_done_q;
  logic          tx_line_q;
  logic [8:0]    tx_shift_q;
  logic [3:0]    tx_bit_q;
  logic [BW-1:0] tx_baud_q;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_line_q  <= 1'b1;
      tx_shift_q <= '0;
      tx_bit_q   <= '0;
      tx_baud_q  <= '0;
    end else begin
      tx_done_q <= 1'b0;
      if (!tx_busy_q) begin
        if (tx_start) begin
          tx_busy_q  <= 1'b1;
          tx_line_q  <= 1'b0;
          tx_shift_q <= {1'b1, tx_byte};
          tx_bit_q   <= '0;
          tx_baud_q  <= BW'(Cpb - 1);
        end
      end else if (tx_baud_q != '0) begin
        tx_baud_q <= tx_baud_q - 1'b1;
      end else begin
        tx_baud_q <= BW'(Cpb - 1);
        if (tx_bit_q == 4'd9) begin
          tx_busy_q <= 1'b0;
          tx_done_q <= 1'b1;
          tx_line_q <= 1'b1;
        end else begin
          tx_line_q  <= tx_shift_q[0];
          tx_shift_q <= {1'b1, tx_shift_q[8:1]};
          tx_bit_q   <= tx_bit_q + 4'd1;
        end
      end
    end
  end

  assign oTx = tx_line_q;

  // ---------------- frame control ----------------
  state_e        state_q, state_d;
  logic [7:0]    buf_q [NBYTES_MAX];
  logic [CW-1:0] cnt_q, len_q, close_len;
  logic [IW-1:0] idx_q;
  logic [RW-1:0] rem_q;
  logic [TW-1:0] tmo_q;
  logic          mode_q;
  logic [7:0]    frame_cnt_q, drop_cnt_q;
  logic [7:0]    cksum_q;
  logic          in_rx, rx_term, store, tmo_hit, close;

  assign in_rx     = (state_q == StRx);
  assign rx_term   = rx_done_q && (rx_shift_q == TERM_BYTE);
  assign store     = in_rx && rx_done_q && !rx_term;
  // A byte landing on the timeout cycle wins; the timeout is simply suppressed.
  assign tmo_hit   = (cnt_q != '0) && !rx_done_q && (tmo_q == TW'(TIMEOUT_CYC));
  assign close     = in_rx && ((rx_term && cnt_q != '0) ||
                               (store && cnt_q == CW'(NBYTES_MAX - 1)) || tmo_hit);
  assign close_len = store ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) state_q <= StRx;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRx:     if (close) state_d = StTxLoad;
      StTxLoad: if (!tx_busy_q) state_d = StTxWait;
      StTxWait: if (tx_done_q) state_d = (rem_q == RW'(1)) ? StDone : StTxLoad;
      StDone:   state_d = StRx;
      default:  state_d = StRx;
    endcase
  end

  always_comb begin
    oBusy    = (state_q == StTxLoad) || (state_q == StTxWait);
    tx_start = (state_q == StTxLoad) && !tx_busy_q;
`ifdef UART_FRAME_CKSUM_EN
    tx_byte  = (rem_q == RW'(1)) ? cksum_q : buf_q[idx_q];
`else
    tx_byte  = buf_q[idx_q];
`endif
  end

  always_ff @(posedge iClk) begin
    if (store) buf_q[cnt_q[IW-1:0]] <= rx_shift_q;
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      cnt_q       <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      rem_q       <= '0;
      tmo_q       <= '0;
      mode_q      <= 1'b0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (in_rx) begin
        if (rx_done_q || close) tmo_q <= '0;
        else if (cnt_q != '0)   tmo_q <= tmo_q + 1'b1;
        if (close) begin
          cnt_q  <= '0;
          len_q  <= close_len;
          mode_q <= iMode;
          idx_q  <= iMode ? IW'(close_len - 1'b1) : '0;
          rem_q  <= RW'(close_len) + RW'(CkExtra);
        end else if (store) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        tmo_q <= '0;
      end
      if (rx_done_q && !in_rx && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
      if (state_q == StTxWait && tx_done_q) begin
        rem_q <= rem_q - 1'b1;
        idx_q <= mode_q ? idx_q - 1'b1 : idx_q + 1'b1;
        if (rem_q == RW'(1)) frame_cnt_q <= frame_cnt_q + 8'd1;
      end
    end
  end

`ifdef UART_FRAME_CKSUM_EN
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN)                 cksum_q <= 8'h00;
    else if (store)             cksum_q <= cksum_q ^ rx_shift_q;
    else if (state_q == StDone) cksum_q <= 8'h00;
  end
`else
  assign cksum_q = 8'h00;
`endif

  assign oFrameLen = len_q;
  assign oFrameCnt = frame_cnt_q;
  assign oDropCnt  = drop_cnt_q;

endmodule

// File: tb/tb_uart_frame_echo.sv
// Directed bench for uart_frame_echo: serial stimulus, serial decode of oTx, immediate asserts.
// Expected echo includes the XOR checksum byte when UART_FRAME_CKSUM_EN is defined.
module tb_uart_frame_echo;
  localparam int unsigned NB  = 4;
  localparam int unsigned CPB = 10;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic       mode  = 1'b0;
  logic       tx;
  logic       busy;
  logic [2:0] flen;
  logic [7:0] fcnt;
  logic [7:0] dcnt;
  int         total = 0;
  int         bad   = 0;
  logic [7:0] rxq[$];

  always #5 clk = ~clk;

  uart_frame_echo #(
    .NBYTES_MAX (NB),
    .CLK_FREQ   (1_000_000),
    .BAUD_RATE  (100_000),
    .TERM_BYTE  (8'h0D),
    .TIMEOUT_CYC(400)
  ) dut (
    .iClk     (clk),
    .iRstN    (rst_n),
    .iRx      (rx),
    .oTx      (tx),
    .iMode    (mode),
    .oBusy    (busy),
    .oFrameLen(flen),
    .oFrameCnt(fcnt),
    .oDropCnt (dcnt)
  );

  // Serial decoder for oTx, sampling mid-bit on the falling clock edge.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge tx);
      repeat (CPB / 2) @(negedge clk);
      if (tx == 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        rxq.push_back(b);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx = f[i];
      repeat (CPB - 1) @(negedge clk);
    end
    repeat (CPB) @(negedge clk);
  endtask

  task automatic wait_frames(input string tag, input logic [7:0] n);
    int k = 0;
    while (fcnt !== n && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check(tag, fcnt, n);
    repeat (20) @(negedge clk);
  endtask

  // e holds byte i at bits [8*i +: 8]; checksum is appended when enabled.
  task automatic check_frame(input string tag, input logic [63:0] e, input int n);
    logic [7:0] ck;
    int         m;
    ck = 8'h00;
    m  = n;
    for (int i = 0; i < n; i++) ck = ck ^ e[8*i +: 8];
`ifdef UART_FRAME_CKSUM_EN
    e[8*n +: 8] = ck;
    m = n + 1;
`endif
    check($sformatf("%s nbytes", tag), rxq.size(), m);
    for (int i = 0; i < m && i < rxq.size(); i++)
      check($sformatf("%s byte%0d", tag, i), rxq[i], e[8*i +: 8]);
    rxq.delete();
  endtask

  initial begin
    // Reset state
    repeat (5) @(negedge clk);
    check("rst tx", tx, 1'b1);
    check("rst busy", busy, 1'b0);
    check("rst flen", flen, 3'd0);
    check("rst fcnt", fcnt, 8'd0);
    check("rst dcnt", dcnt, 8'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 1: forward echo
    mode = 1'b0;
    send_byte(8'h41); send_byte(8'h42); send_byte(8'h43); send_byte(8'h0D);
    wait_frames("t1 fcnt", 8'd1);
    check_frame("t1", 64'h434241, 3);
    check("t1 flen", flen, 3'd3);
    check("t1 busy", busy, 1'b0);

    // 2: reversed echo, iMode toggled mid-frame and after close
    mode = 1'b1;
    send_byte(8'h41);
    mode = 1'b0;
    send_byte(8'h42);
    mode = 1'b1;
    send_byte(8'h43); send_byte(8'h0D);
    mode = 1'b0;
    wait_frames("t2 fcnt", 8'd2);
    check_frame("t2", 64'h414243, 3);
    check("t2 flen", flen, 3'd3);

    // 3: buffer-full close, byte dropped while busy, lone terminator ignored
    send_byte(8'h31); send_byte(8'h32); send_byte(8'h33); send_byte(8'h34);
    send_byte(8'h35);
    wait_frames("t3 fcnt", 8'd3);
    check_frame("t3", 64'h34333231, 4);
    check("t3 flen", flen, 3'd4);
    check("t3 dcnt", dcnt, 8'd1);
    send_byte(8'h0D);
    repeat (100) @(negedge clk);
    check("t3 term fcnt", fcnt, 8'd3);
    check("t3 term busy", busy, 1'b0);
    check("t3 term nbytes", rxq.size(), 0);
    check("t3 term dcnt", dcnt, 8'd1);

    // 4: timeout close
    send_byte(8'h41); send_byte(8'h42);
    repeat (200) @(negedge clk);
    check("t4 early busy", busy, 1'b0);
    check("t4 early fcnt", fcnt, 8'd3);
    wait_frames("t4 fcnt", 8'd4);
    check_frame("t4", 64'h4241, 2);
    check("t4 flen", flen, 3'd2);

    // 5: checksum pattern
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h0D);
    wait_frames("t5 fcnt", 8'd5);
    check_frame("t5", 64'h040201, 3);

    // 6: reset during second transmitted byte
    send_byte(8'h58); send_byte(8'h59); send_byte(8'h5A); send_byte(8'h0D);
    begin
      int k = 0;
      while (rxq.size() < 1 && k < 1000) begin
        @(negedge clk);
        k++;
      end
      check("t6 first byte seen", (rxq.size() >= 1), 1'b1);
    end
    repeat (30) @(negedge clk);
    check("t6 busy before rst", busy, 1'b1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("t6 rst tx", tx, 1'b1);
    check("t6 rst busy", busy, 1'b0);
    check("t6 rst flen", flen, 3'd0);
    check("t6 rst fcnt", fcnt, 8'd0);
    check("t6 rst dcnt", dcnt, 8'd0);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    rxq.delete();
    send_byte(8'h48); send_byte(8'h49); send_byte(8'h0D);
    wait_frames("t6 fcnt", 8'd1);
    check_frame("t6", 64'h4948, 2);
    check("t6 flen", flen, 3'd2);
    check("t6 tx idle", tx, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
